// File: rtl/sha256_multicore_sched_if.sv
`default_nettype none
// =============================================================================
// sha256_multicore_sched_if : block-in / digest-out / core-bank bundle
// Rev 1.0
// =============================================================================
interface sha256_multicore_sched_if #(
  parameter int num_cores_p    = 4,
  parameter int block_width_p  = 512,
  parameter int digest_width_p = 256
);
  localparam int ID_W  = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;
  localparam int CNT_W = $clog2(num_cores_p + 1);

  logic                                  en_i;
  logic                                  v_i;
  logic [block_width_p-1:0]              data_i;
  logic                                  ready_o;
  logic                                  v_o;
  logic [digest_width_p-1:0]             data_o;
  logic [ID_W-1:0]                       core_id_o;
  logic                                  yumi_i;
  logic [num_cores_p-1:0]                core_v_o;
  logic [block_width_p-1:0]              core_block_o;
  logic [num_cores_p-1:0]                core_ready_i;
  logic [num_cores_p-1:0]                core_v_i;
  logic [num_cores_p*digest_width_p-1:0] core_digest_i;
  logic [num_cores_p-1:0]                core_yumi_o;
  logic [CNT_W-1:0]                      inflight_o;

  modport slave (
    input  en_i, v_i, data_i, yumi_i, core_ready_i, core_v_i, core_digest_i,
    output ready_o, v_o, data_o, core_id_o, core_v_o, core_block_o, core_yumi_o, inflight_o
  );

  modport master (
    output en_i, v_i, data_i, yumi_i, core_ready_i, core_v_i, core_digest_i,
    input  ready_o, v_o, data_o, core_id_o, core_v_o, core_block_o, core_yumi_o, inflight_o
  );
endinterface
`default_nettype wire

// File: rtl/sha256_multicore_sched.sv
`default_nettype none
// =============================================================================
// sha256_multicore_sched : streaming dispatch/collect controller for SHA-256 cores
// Rev 1.0
// =============================================================================
module sha256_multicore_sched #(
  parameter int num_cores_p    = 4,
  parameter int block_width_p  = 512,
  parameter int digest_width_p = 256,
  parameter int ordered_p      = 1
) (
  input  wire logic               clk_i,
  input  wire logic               reset_i,
  sha256_multicore_sched_if.slave bus
);
  localparam int ID_W  = (num_cores_p > 1) ? $clog2(num_cores_p) : 1;
  localparam int CNT_W = $clog2(num_cores_p + 1);
  localparam logic [num_cores_p-1:0] LSB_ONE = num_cores_p'(1);

  logic [ID_W-1:0]           r_wr_ptr;
  logic [ID_W-1:0]           r_rd_ptr;
  logic [num_cores_p-1:0]    r_busy;
  logic                      r_v;
  logic [digest_width_p-1:0] r_data;
  logic [ID_W-1:0]           r_core_id;
  logic [CNT_W-1:0]          r_inflight;

  logic [num_cores_p-1:0]    w_free;
  logic [num_cores_p-1:0]    w_elig;
  logic [num_cores_p-1:0]    w_disp_oh;
  logic [num_cores_p-1:0]    w_load_oh;
  logic [ID_W-1:0]           w_disp_idx;
  logic [ID_W-1:0]           w_sel_idx;
  logic                      w_disp_ok;
  logic                      w_sel_ok;
  logic                      w_accept;
  logic                      w_load;

  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int off);
    int s;
    s = 32'(base) + off;
    if (s >= num_cores_p) s = s - num_cores_p;
    return ID_W'(s);
  endfunction

  assign w_free = ~r_busy & bus.core_ready_i;
  assign w_elig = r_busy & bus.core_v_i;

  if (ordered_p != 0) begin : g_ordered
    assign w_disp_idx = r_wr_ptr;
    assign w_disp_ok  = w_free[r_wr_ptr];
    assign w_sel_idx  = r_rd_ptr;
    assign w_sel_ok   = w_elig[r_rd_ptr];
  end else begin : g_fair
    // Walk from the far end so the candidate nearest the pointer is written last and wins.
    always_comb begin
      w_disp_ok  = 1'b0;
      w_disp_idx = r_wr_ptr;
      w_sel_ok   = 1'b0;
      w_sel_idx  = r_rd_ptr;
      for (int i = num_cores_p - 1; i >= 0; i--) begin
        if (w_free[wrap_add(r_wr_ptr, i)]) begin
          w_disp_ok  = 1'b1;
          w_disp_idx = wrap_add(r_wr_ptr, i);
        end
        if (w_elig[wrap_add(r_rd_ptr, i)]) begin
          w_sel_ok  = 1'b1;
          w_sel_idx = wrap_add(r_rd_ptr, i);
        end
      end
    end
  end

  // Gating with reset_i keeps the strobes quiet while the bank is being reset.
  assign w_accept  = reset_i & bus.en_i & w_disp_ok & bus.v_i;
  assign w_load    = reset_i & bus.en_i & w_sel_ok & (~r_v | bus.yumi_i);
  assign w_disp_oh = w_accept ? (LSB_ONE << w_disp_idx) : '0;
  assign w_load_oh = w_load ? (LSB_ONE << w_sel_idx) : '0;

  assign bus.ready_o      = reset_i & bus.en_i & w_disp_ok;
  assign bus.core_v_o     = w_disp_oh;
  assign bus.core_block_o = bus.data_i;
  assign bus.core_yumi_o  = w_load_oh;
  assign bus.v_o          = r_v;
  assign bus.data_o       = r_data;
  assign bus.core_id_o    = r_core_id;
  assign bus.inflight_o   = r_inflight;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_busy     <= '0;
      r_v        <= 1'b0;
      r_data     <= '0;
      r_core_id  <= '0;
      r_inflight <= '0;
    end else begin
      r_busy <= (r_busy | w_disp_oh) & ~w_load_oh;
      if (w_accept) r_wr_ptr <= wrap_add(w_disp_idx, 1);
      if (w_load) begin
        r_v       <= 1'b1;
        r_data    <= bus.core_digest_i[w_sel_idx*digest_width_p +: digest_width_p];
        r_core_id <= w_sel_idx;
        r_rd_ptr  <= wrap_add(w_sel_idx, 1);
      end else if (bus.yumi_i) begin
        r_v <= 1'b0;
      end
      if (w_accept && !w_load) r_inflight <= r_inflight + CNT_W'(1);
      else if (!w_accept && w_load) r_inflight <= r_inflight - CNT_W'(1);
    end
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_i) bus.yumi_i |-> r_v);

endmodule
`default_nettype wire

// File: tb/tb_sha256_multicore_sched.sv
`default_nettype none
// =============================================================================
// tb_sha256_multicore_sched : ordered and fair instances side by side vs a model
// Rev 1.0
// =============================================================================
module tb_sha256_multicore_sched;
  localparam int N  = 4;
  localparam int BW = 512;
  localparam int DW = 256;

  logic clk_i = 1'b0;
  logic reset_i;
  logic en_i;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  logic [BW-1:0] src_q     [2][$];
  int            disp_id   [2][$];
  int            disp_cyc  [2][$];
  int            take_id   [2][$];
  logic [DW-1:0] take_data [2][$];
  int            take_cyc  [2][$];
  int            yumi_cnt  [2];
  int            max_infl  [2];
  int            y0_cyc    [2];
  int            m_cnt     [2];
  bit            m_vpub    [2];
  int            lat       [N];
  bit            take_en;

  function automatic logic [DW-1:0] digest_of(input logic [BW-1:0] b);
    return {b[127:0], ~b[127:0]};
  endfunction

  task automatic chk(input int inst, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h expected=%0h", name, inst, act, exp);
    end
  endtask

  // Instance 0 is ordered, instance 1 is fair; each has its own cores, consumer and model.
  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    sha256_multicore_sched_if #(.num_cores_p(N), .block_width_p(BW), .digest_width_p(DW)) bus ();
    sha256_multicore_sched #(
      .num_cores_p(N), .block_width_p(BW), .digest_width_p(DW), .ordered_p(1 - gi)
    ) dut (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .bus    (bus)
    );
    assign bus.en_i = en_i;

    int            c_cnt [N];
    bit            c_busy[N];
    bit            c_done[N];
    logic [BW-1:0] c_blk [N];
    bit            m_own [N];
    logic [BW-1:0] m_blk [N];
    int            m_order[$];
    int            m_acc, m_wr, m_rd, m_id;
    bit            m_v;
    logic [DW-1:0] m_data;

    initial begin : p_inst
      int            tgt, cand, n_own;
      bit            exp_ready, acc, ld, rst_s, src_pop;
      logic [N-1:0]  disp, yum, exp_oh;
      logic [BW-1:0] data_s;
      bus.v_i = 1'b0; bus.data_i = '0; bus.yumi_i = 1'b0;
      bus.core_ready_i = '0; bus.core_v_i = '0; bus.core_digest_i = '0;
      m_acc = 0; m_wr = 0; m_rd = 0; m_id = 0; m_v = 1'b0; m_data = '0;
      for (int k = 0; k < N; k++) begin
        c_cnt[k] = 0; c_busy[k] = 1'b0; c_done[k] = 1'b0; c_blk[k] = '0; m_own[k] = 1'b0; m_blk[k] = '0;
      end
      forever begin
        @(negedge clk_i);
        disp = bus.core_v_o; yum = bus.core_yumi_o; rst_s = reset_i; data_s = bus.data_i;
        src_pop = 1'b0;
        if (!reset_i) begin
          chk(gi, "rst_ready", bus.ready_o, 0);
          chk(gi, "rst_core_v", bus.core_v_o, 0);
          chk(gi, "rst_core_yumi", bus.core_yumi_o, 0);
          chk(gi, "rst_v_o", bus.v_o, 0);
          chk(gi, "rst_data_o", bus.data_o, 0);
          chk(gi, "rst_core_id", bus.core_id_o, 0);
          chk(gi, "rst_inflight", bus.inflight_o, 0);
          for (int k = 0; k < N; k++) m_own[k] = 1'b0;
          m_order.delete();
          m_acc = 0; m_wr = 0; m_rd = 0; m_v = 1'b0; m_data = '0; m_id = 0;
        end else begin
          n_own = 0;
          for (int k = 0; k < N; k++) if (m_own[k]) n_own++;
          chk(gi, "v_o", bus.v_o, m_v);
          chk(gi, "inflight", bus.inflight_o, n_own);
          if (m_v) begin
            chk(gi, "data_o", bus.data_o, m_data);
            chk(gi, "core_id", bus.core_id_o, m_id);
          end
          // Ordered targets follow the acceptance count; fair targets search from last+1.
          tgt = -1;
          if (gi == 0) begin
            if (!m_own[m_acc % N] && bus.core_ready_i[m_acc % N]) tgt = m_acc % N;
          end else begin
            for (int j = 0; j < N; j++)
              if (tgt < 0 && !m_own[(m_wr + j) % N] && bus.core_ready_i[(m_wr + j) % N]) tgt = (m_wr + j) % N;
          end
          exp_ready = en_i && (tgt >= 0);
          acc = exp_ready && bus.v_i;
          chk(gi, "ready_o", bus.ready_o, exp_ready);
          exp_oh = '0;
          if (acc) exp_oh[tgt] = 1'b1;
          chk(gi, "core_v_o", bus.core_v_o, exp_oh);
          if (bus.v_i) chk(gi, "core_block", bus.core_block_o == bus.data_i, 1);
          cand = -1;
          if (gi == 0) begin
            if (m_order.size() > 0 && bus.core_v_i[m_order[0]]) cand = m_order[0];
          end else begin
            for (int j = 0; j < N; j++)
              if (cand < 0 && m_own[(m_rd + j) % N] && bus.core_v_i[(m_rd + j) % N]) cand = (m_rd + j) % N;
          end
          ld = en_i && (cand >= 0) && (!m_v || bus.yumi_i);
          exp_oh = '0;
          if (ld) exp_oh[cand] = 1'b1;
          chk(gi, "core_yumi_o", bus.core_yumi_o, exp_oh);

          if (bus.yumi_i && bus.v_o) begin
            take_id[gi].push_back(int'(bus.core_id_o));
            take_data[gi].push_back(bus.data_o);
            take_cyc[gi].push_back(cyc);
          end
          if (|yum) yumi_cnt[gi]++;
          if (yum[0] && y0_cyc[gi] < 0) y0_cyc[gi] = cyc;
          for (int k = 0; k < N; k++)
            if (disp[k]) begin disp_id[gi].push_back(k); disp_cyc[gi].push_back(cyc); end
          if (int'(bus.inflight_o) > max_infl[gi]) max_infl[gi] = int'(bus.inflight_o);

          if (ld) begin
            m_v = 1'b1; m_data = digest_of(m_blk[cand]); m_id = cand;
            m_rd = (cand + 1) % N; m_own[cand] = 1'b0;
            if (gi == 0) void'(m_order.pop_front());
          end else if (bus.yumi_i) begin
            m_v = 1'b0;
          end
          if (acc) begin
            m_own[tgt] = 1'b1; m_blk[tgt] = bus.data_i; m_acc++; m_wr = (tgt + 1) % N;
            if (gi == 0) m_order.push_back(tgt);
          end
          src_pop = bus.v_i && bus.ready_o;
        end
        n_own = 0;
        for (int k = 0; k < N; k++) if (m_own[k]) n_own++;
        m_cnt[gi] = n_own; m_vpub[gi] = m_v;

        @(posedge clk_i); #1;
        if (src_pop && src_q[gi].size() > 0) void'(src_q[gi].pop_front());
        for (int k = 0; k < N; k++) begin
          if (!rst_s) begin
            c_busy[k] = 1'b0; c_done[k] = 1'b0; c_cnt[k] = 0;
          end else begin
            if (c_busy[k] && !c_done[k]) begin
              c_cnt[k]--;
              if (c_cnt[k] <= 0) c_done[k] = 1'b1;
            end
            if (yum[k]) begin c_busy[k] = 1'b0; c_done[k] = 1'b0; end
            if (disp[k]) begin c_busy[k] = 1'b1; c_done[k] = 1'b0; c_cnt[k] = lat[k]; c_blk[k] = data_s; end
          end
          bus.core_ready_i[k] = !c_busy[k];
          bus.core_v_i[k]     = c_done[k];
          bus.core_digest_i[k*DW +: DW] = digest_of(c_blk[k]);
        end
        bus.v_i    = (src_q[gi].size() > 0);
        bus.data_i = (src_q[gi].size() > 0) ? src_q[gi][0] : '0;
        bus.yumi_i = take_en && bus.v_o;
      end
    end
  end

  task automatic clear_rec();
    for (int i = 0; i < 2; i++) begin
      disp_id[i].delete(); disp_cyc[i].delete(); take_id[i].delete(); take_data[i].delete(); take_cyc[i].delete();
      yumi_cnt[i] = 0; max_infl[i] = 0; y0_cyc[i] = -1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    src_q[0].delete(); src_q[1].delete();
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    clear_rec();
  endtask

  task automatic push_blocks(input int first, input int count);
    for (int b = 0; b < count; b++) begin
      src_q[0].push_back(BW'(first + b));
      src_q[1].push_back(BW'(first + b));
    end
  endtask

  task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!(src_q[0].size() == 0 && src_q[1].size() == 0 && m_cnt[0] == 0 && m_cnt[1] == 0 &&
             !m_vpub[0] && !m_vpub[1]) && n < budget) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    chk(0, "drain_timeout", (n < budget), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin : p_main
    int exp_ord [4];
    int exp_fair[4];
    int exp_disp[6];
    exp_ord  = '{0, 1, 2, 3};
    exp_fair = '{3, 2, 1, 0};
    exp_disp = '{0, 1, 2, 3, 0, 1};
    reset_i = 1'b1; en_i = 1'b1; take_en = 1'b0;
    set_lat(2, 2, 2, 2);
    clear_rec();
    #2 reset_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b1;

    // Reverse completion: ordered collects 0..3, fair collects 3..0.
    do_reset();
    set_lat(12, 9, 6, 3); take_en = 1'b1;
    push_blocks(1, 4);
    wait_drain(100);
    chk(0, "t1_count", take_id[0].size(), 4);
    chk(1, "t1_count", take_id[1].size(), 4);
    for (int j = 0; j < 4; j++) begin
      if (j < take_id[0].size()) chk(0, "t1_order", take_id[0][j], exp_ord[j]);
      if (j < take_id[1].size()) chk(1, "t1_order", take_id[1][j], exp_fair[j]);
    end
    if (take_data[0].size() > 0)
      chk(0, "t1_first_digest", take_data[0][0],
          256'h00000000_00000000_00000000_00000001_ffffffff_ffffffff_ffffffff_fffffffe);
    if (take_data[1].size() > 0)
      chk(1, "t1_first_digest", take_data[1][0],
          256'h00000000_00000000_00000000_00000004_ffffffff_ffffffff_ffffffff_fffffffb);
    chk(0, "t1_peak_inflight", max_infl[0], 4);
    chk(1, "t1_peak_inflight", max_infl[1], 4);

    // All cores finished, consumer then takes continuously: four back-to-back digests.
    do_reset();
    set_lat(2, 2, 2, 2); take_en = 1'b0;
    push_blocks(8, 4);
    repeat (12) @(posedge clk_i);
    #1;
    take_en = 1'b1;
    wait_drain(50);
    chk(0, "t3_takes", take_cyc[0].size(), 4);
    chk(1, "t3_takes", take_cyc[1].size(), 4);
    for (int j = 0; j + 1 < 4; j++) begin
      if (j + 1 < take_cyc[0].size()) chk(0, "t3_back_to_back", take_cyc[0][j+1] - take_cyc[0][j], 1);
      if (j + 1 < take_cyc[1].size()) chk(1, "t3_back_to_back", take_cyc[1][j+1] - take_cyc[1][j], 1);
    end

    // One digest held without yumi: single core pulse, stable output, then en_i=0 still honours yumi.
    do_reset();
    set_lat(2, 2, 2, 2); take_en = 1'b0;
    push_blocks(5, 1);
    repeat (14) @(posedge clk_i);
    #1;
    chk(0, "t4_yumi_pulses", yumi_cnt[0], 1);
    chk(1, "t4_yumi_pulses", yumi_cnt[1], 1);
    chk(0, "t4_v_held", g_inst[0].bus.v_o, 1);
    chk(1, "t4_v_held", g_inst[1].bus.v_o, 1);
    chk(0, "t4_data_held", g_inst[0].bus.data_o,
        256'h00000000_00000000_00000000_00000005_ffffffff_ffffffff_ffffffff_fffffffa);
    en_i = 1'b0; take_en = 1'b1;
    push_blocks(6, 1);
    repeat (3) @(posedge clk_i);
    #1;
    chk(0, "t4_en_off_v", g_inst[0].bus.v_o, 0);
    chk(1, "t4_en_off_v", g_inst[1].bus.v_o, 0);
    chk(0, "t4_en_off_disp", disp_id[0].size(), 1);
    chk(1, "t4_en_off_disp", disp_id[1].size(), 1);
    en_i = 1'b1;
    wait_drain(50);

    // Six blocks through four cores: pointer wraps, fifth block waits for core 0 to be collected.
    do_reset();
    set_lat(4, 4, 4, 4); take_en = 1'b1;
    push_blocks(32, 6);
    wait_drain(100);
    chk(0, "t5_disp_count", disp_id[0].size(), 6);
    chk(1, "t5_disp_count", disp_id[1].size(), 6);
    for (int j = 0; j < 6; j++) begin
      if (j < disp_id[0].size()) chk(0, "t5_disp_core", disp_id[0][j], exp_disp[j]);
      if (j < disp_id[1].size()) chk(1, "t5_disp_core", disp_id[1][j], exp_disp[j]);
    end
    if (disp_cyc[0].size() > 4) chk(0, "t5_fifth_after_load", disp_cyc[0][4] > y0_cyc[0], 1);
    if (disp_cyc[1].size() > 4) chk(1, "t5_fifth_after_load", disp_cyc[1][4] > y0_cyc[1], 1);

    // Reset with three blocks in flight discards them; the next block restarts at core 0.
    do_reset();
    set_lat(20, 20, 20, 20); take_en = 1'b1;
    push_blocks(17, 3);
    repeat (6) @(posedge clk_i);
    #1;
    chk(0, "t6_inflight_pre", g_inst[0].bus.inflight_o, 3);
    chk(1, "t6_inflight_pre", g_inst[1].bus.inflight_o, 3);
    reset_i = 1'b0;
    src_q[0].delete(); src_q[1].delete();
    @(negedge clk_i);
    chk(0, "t6_v_after_rst", g_inst[0].bus.v_o, 0);
    chk(1, "t6_v_after_rst", g_inst[1].bus.v_o, 0);
    chk(0, "t6_infl_after_rst", g_inst[0].bus.inflight_o, 0);
    chk(1, "t6_infl_after_rst", g_inst[1].bus.inflight_o, 0);
    chk(0, "t6_ready_in_rst", g_inst[0].bus.ready_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    clear_rec();
    set_lat(2, 2, 2, 2);
    push_blocks(119, 1);
    wait_drain(60);
    chk(0, "t6_post_disp_count", disp_id[0].size(), 1);
    chk(1, "t6_post_disp_count", disp_id[1].size(), 1);
    if (disp_id[0].size() > 0) chk(0, "t6_post_core", disp_id[0][0], 0);
    if (disp_id[1].size() > 0) chk(1, "t6_post_core", disp_id[1][0], 0);

    repeat (2) @(posedge clk_i);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
